// File: rtl/ib_ram_update_ctrl_pkg.sv
// ib_ram_update_ctrl_pkg: shared FSM encoding, default widths and page-counter sizing.
package ib_ram_update_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, DONE} state_t;
  localparam int QUAN_SIZE     = 4;
  localparam int LUT_PORT_SIZE = 3;
  localparam int BANK_NUM      = 2;
  localparam int ENTRY_ADDR    = 5;
  function automatic int page_cnt_w(input int page_num);
    return (page_num > 1) ? $clog2(page_num) : 1;
  endfunction
endpackage

// File: rtl/ib_ram_update_ctrl_drain_timer.sv
// ib_drain_timer: reloadable read-pipeline drain counter; expire flags the cycle the pipeline is empty.
module ib_drain_timer #(
  parameter int PIPELINE_DEPTH = 3
) (
  input  logic write_clk,
  input  logic rst,
  input  logic en,
  input  logic datapath_active,
  output logic expire
);
  localparam int CW = (PIPELINE_DEPTH > 0) ? $clog2(PIPELINE_DEPTH + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (!en || datapath_active || cnt_q == '0) ? CW'(PIPELINE_DEPTH) : cnt_q - 1'b1;
  assign expire = en && !datapath_active && cnt_q == '0;
  always_ff @(posedge write_clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/ib_ram_update_ctrl.sv
// ib_ram_update_ctrl: drains the VNU read pipeline, then streams one frame region of LUT pages into the RAM write port.
// Optional IB_RAM_WR_CHKSUM_EN adds wr_chksum, the XOR of all data written by the current update.
module ib_ram_update_ctrl #(
  parameter int ENTRY_ADDR      = ib_ram_update_ctrl_pkg::ENTRY_ADDR,
  parameter int MULTI_FRAME_NUM = 2,
  parameter int LUT_PORT_SIZE   = ib_ram_update_ctrl_pkg::LUT_PORT_SIZE,
  parameter int BANK_NUM        = ib_ram_update_ctrl_pkg::BANK_NUM,
  parameter int PAGE_NUM        = 16,
  parameter int PIPELINE_DEPTH  = 3,
  parameter int ITER_MAX        = 10
) (
  input  logic                              write_clk,
  input  logic                              rst,
  input  logic                              update_req,
  input  logic                              update_frame,
  input  logic                              datapath_active,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] lut_data,
  input  logic                              lut_data_valid,
  output logic                              lut_data_ready,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_0,
  output logic                              ib_ram_we,
  output logic                              update_busy,
  output logic                              update_done,
  output logic [$clog2(ITER_MAX)-1:0]       iter_cnt,
  output logic                              last_iter
`ifdef IB_RAM_WR_CHKSUM_EN
  ,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] wr_chksum
`endif
);
  import ib_ram_update_ctrl_pkg::*;
  localparam int DW  = LUT_PORT_SIZE * BANK_NUM;
  localparam int FW  = (MULTI_FRAME_NUM > 1) ? $clog2(MULTI_FRAME_NUM) : 1;
  localparam int AW  = ENTRY_ADDR - FW;
  localparam int PCW = page_cnt_w(PAGE_NUM);
  localparam int IW  = $clog2(ITER_MAX);
  state_t          state_q, state_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [PCW-1:0]  page_q, page_d;
  logic [ENTRY_ADDR-1:0] addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic            we_q, we_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d, last_q, last_d;
  logic            beat, last_beat, accept, expire;
  ib_drain_timer #(.PIPELINE_DEPTH(PIPELINE_DEPTH)) u_drain (
    .write_clk      (write_clk),
    .rst            (rst),
    .en             (state_q == DRAIN),
    .datapath_active(datapath_active),
    .expire         (expire)
  );
  always_comb begin
    beat      = state_q == LOAD && lut_data_valid;
    last_beat = beat && page_q == PCW'(PAGE_NUM - 1);
    accept    = state_q == IDLE && update_req;
    state_d   = state_q;
    unique case (state_q)
      IDLE:    state_d = update_req ? DRAIN : IDLE;
      DRAIN:   state_d = expire ? LOAD : DRAIN;
      LOAD:    state_d = last_beat ? DONE : LOAD;
      default: state_d = IDLE;
    endcase
    frame_d = accept ? FW'(update_frame) : frame_q;
    busy_d  = accept || (busy_q && state_q != DONE);
    done_d  = state_q == DONE;
    // ready is registered but looks ahead at state_d so it falls with the final beat
    ready_d = state_d == LOAD;
    we_d    = beat;
    data_d  = beat ? lut_data : data_q;
    addr_d  = beat ? {frame_q, AW'(page_q)} : addr_q;
    page_d  = last_beat ? '0 : beat ? page_q + 1'b1 : page_q;
    iter_d  = done_d ? (last_q ? '0 : iter_q + 1'b1) : iter_q;
    last_d  = iter_d == IW'(ITER_MAX - 1);
  end
  always_ff @(posedge write_clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      page_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      iter_q  <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      page_q  <= page_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      iter_q  <= iter_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end
  assign lut_data_ready   = ready_q;
  assign page_addr_ram    = addr_q;
  assign ram_write_data_0 = data_q;
  assign ib_ram_we        = we_q;
  assign update_busy      = busy_q;
  assign update_done      = done_q;
  assign iter_cnt         = iter_q;
  assign last_iter        = last_q;
`ifdef IB_RAM_WR_CHKSUM_EN
  logic [DW-1:0] chk_q, chk_d;
  always_comb chk_d = accept ? '0 : beat ? chk_q ^ lut_data : chk_q;
  always_ff @(posedge write_clk) chk_q <= rst ? '0 : chk_d;
  assign wr_chksum = chk_q;
`endif
endmodule

// File: tb/tb_ib_ram_update_ctrl.sv
// tb_ib_ram_update_ctrl: directed checks of latency, drain reload, backpressure, iteration wrap and reset mid-load.
module tb_ib_ram_update_ctrl;
  logic       write_clk, rst, update_req, update_frame, datapath_active, lut_data_valid;
  logic [5:0] lut_data, ram_write_data_0;
  logic       lut_data_ready, ib_ram_we, update_busy, update_done, last_iter;
  logic [4:0] page_addr_ram;
  logic [3:0] iter_cnt;
`ifdef IB_RAM_WR_CHKSUM_EN
  logic [5:0] wr_chksum;
`endif
  int n_chk = 0, n_fail = 0;
  int nwr, first_we, first_rdy, ndone, bad_a, bad_d, bad_we;
  logic busy_at_done;
  logic [5:0] chk_done;
  ib_ram_update_ctrl dut (
    .write_clk       (write_clk),
    .rst             (rst),
    .update_req      (update_req),
    .update_frame    (update_frame),
    .datapath_active (datapath_active),
    .lut_data        (lut_data),
    .lut_data_valid  (lut_data_valid),
    .lut_data_ready  (lut_data_ready),
    .page_addr_ram   (page_addr_ram),
    .ram_write_data_0(ram_write_data_0),
    .ib_ram_we       (ib_ram_we),
    .update_busy     (update_busy),
    .update_done     (update_done),
    .iter_cnt        (iter_cnt),
    .last_iter       (last_iter)
`ifdef IB_RAM_WR_CHKSUM_EN
    ,
    .wr_chksum       (wr_chksum)
`endif
  );
  initial write_clk = 0;
  always #5 write_clk = ~write_clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge write_clk);
    #1;
  endtask
  function automatic logic [5:0] data_of(input int mode, input int k);
    case (mode)
      1:       return 6'(k);
      2:       return (k == 0) ? 6'h2A : 6'h00;
      default: return 6'(k * 7 + 3);
    endcase
  endfunction
  task automatic start(input int frame);
    update_frame = frame[0];
    update_req = 1;
    tick;
    update_req = 0;
  endtask
  // t counts edges after the accepting edge; vmode 1 offers data every third cycle
  task automatic stream(input int frame, input int vmode, input int dmode, input int amode, input bit poke);
    int t, beat;
    logic acc;
    nwr = 0; first_we = -1; first_rdy = -1; ndone = 0; bad_a = 0; bad_d = 0; bad_we = 0;
    t = 0; beat = 0; busy_at_done = 1'bx; chk_done = 'x;
    while (ndone == 0 && t < 300) begin
      datapath_active = (amode == 1 && t < 10) || (amode == 2 && t == 2);
      lut_data_valid = (vmode == 0) || (t % 3 == 0);
      lut_data = lut_data_valid ? data_of(dmode, beat) : 6'h3F;
      update_req = poke && t == 6;
      acc = lut_data_ready && lut_data_valid;
      tick;
      t++;
      update_req = 0;
      if (acc) beat++;
      if (lut_data_ready && first_rdy < 0) first_rdy = t;
      if (ib_ram_we !== acc) bad_we++;
      if (ib_ram_we) begin
        if (first_we < 0) first_we = t;
        if (32'(page_addr_ram) != frame * 16 + nwr) bad_a++;
        if (ram_write_data_0 !== data_of(dmode, nwr)) bad_d++;
        nwr++;
      end
      if (update_done) begin
        ndone++;
        busy_at_done = update_busy;
`ifdef IB_RAM_WR_CHKSUM_EN
        chk_done = wr_chksum;
`endif
      end
    end
    lut_data_valid = 0;
    datapath_active = 0;
  endtask
  task automatic post(input string tag);
    chk({tag, "_writes"}, nwr, 16);
    chk({tag, "_addr_err"}, bad_a, 0);
    chk({tag, "_data_err"}, bad_d, 0);
    chk({tag, "_we_vs_beat"}, bad_we, 0);
    chk({tag, "_done_seen"}, ndone, 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
    tick;
    chk({tag, "_done_pulse"}, update_done, 0);
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, ib_ram_we, 0);
    chk({tag, "_addr"}, page_addr_ram, 0);
    chk({tag, "_data"}, ram_write_data_0, 0);
    chk({tag, "_ready"}, lut_data_ready, 0);
    chk({tag, "_busy"}, update_busy, 0);
    chk({tag, "_done"}, update_done, 0);
    chk({tag, "_iter"}, iter_cnt, 0);
    chk({tag, "_last"}, last_iter, 0);
`ifdef IB_RAM_WR_CHKSUM_EN
    chk({tag, "_chksum"}, wr_chksum, 0);
`endif
  endtask
  initial begin
    int n;
    logic extra;
    rst = 1; update_req = 0; update_frame = 0; datapath_active = 0; lut_data = '0; lut_data_valid = 0;
    repeat (3) tick;
    rst = 0;
    tick;
    chk_all_zero("reset");
    // basic: minimum latency is depth+2 from the accepting edge
    start(1);
    chk("basic_busy", update_busy, 1);
    stream(1, 0, 0, 0, 0);
    chk("basic_first_rdy", first_rdy, 4);
    chk("basic_first_we", first_we, 5);
    post("basic");
    chk("basic_iter", iter_cnt, 1);
    // active high for ten cycles; ready three edges after the first edge seeing it low
    start(0);
    stream(0, 0, 0, 1, 0);
    chk("drain_first_rdy", first_rdy, 14);
    chk("drain_first_we", first_we, 15);
    post("drain");
    // one-cycle re-pulse while the counter sits at 1 reloads it to 3
    start(1);
    stream(1, 0, 0, 2, 0);
    chk("repulse_first_rdy", first_rdy, 7);
    chk("repulse_first_we", first_we, 8);
    post("repulse");
    start(0);
    stream(0, 1, 0, 0, 0);
    chk("bp_first_rdy", first_rdy, 4);
    post("bp");
    chk("bp_iter", iter_cnt, 4);
    // reset after seven writes
    start(1);
    lut_data_valid = 1;
    n = 0;
    for (int c = 0; c < 60 && n < 7; c++) begin
      lut_data = 6'(c);
      tick;
      if (ib_ram_we) n++;
    end
    chk("rml_writes_before", n, 7);
    rst = 1;
    tick;
    rst = 0;
    lut_data_valid = 0;
    chk_all_zero("rml");
    start(0);
    stream(0, 0, 0, 0, 0);
    chk("restart_first_we", first_we, 5);
    post("restart");
    chk("restart_iter", iter_cnt, 1);
    // restart above is update 1 of the wrap sequence
    for (int k = 2; k <= 10; k++) begin
      start(k % 2);
`ifdef IB_RAM_WR_CHKSUM_EN
      chk("chksum_clear", wr_chksum, 0);
`endif
      stream(k % 2, k % 2, (k == 3) ? 1 : (k == 4) ? 2 : 0, 0, k == 5);
      post($sformatf("wrap%0d", k));
`ifdef IB_RAM_WR_CHKSUM_EN
      if (k == 3) chk("chksum_index", chk_done, 0);
      if (k == 4) chk("chksum_2a", chk_done, 6'h2A);
      if (k == 4) chk("chksum_hold", wr_chksum, 6'h2A);
`endif
      chk($sformatf("wrap%0d_iter", k), iter_cnt, k % 10);
      chk($sformatf("wrap%0d_last", k), last_iter, (k == 9) ? 1 : 0);
      if (k == 5) begin
        extra = 0;
        repeat (6) begin
          tick;
          extra = extra | update_busy | ib_ram_we;
        end
        chk("poke_no_extra", extra, 0);
      end
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
